// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Package : clock_pkg
// Brief   : Mode encodings, BCD width, default maxima and a BCD helper for
//           the time-of-day keeper.
// Rev     : 1.0
// ============================================================================
package clock_pkg;

    localparam int unsigned BCD_W = 8;

    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_SET_HR  = 2'b01;
    localparam logic [1:0] MODE_SET_MIN = 2'b10;

    localparam int unsigned HOURS_MAX_DEF = 23;
    localparam int unsigned MIN_MAX_DEF   = 59;

    // Two-digit decimal value to packed BCD, tens in the upper nibble.
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        return BCD_W'((((v / 10) % 10) << 4) | (v % 10));
    endfunction

endpackage : clock_pkg
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module : bcd_mod_counter
// Brief  : Two-digit BCD counter that wraps from MAX to 00, with a
//          combinational carry on the wrapping increment.
// Rev    : 1.0
// ============================================================================
module bcd_mod_counter #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] r_value;
    logic [7:0] w_next;
    logic       w_at_max;

    assign w_at_max = (r_value == MAX);
    assign carry    = inc & w_at_max;
    assign value    = r_value;

    always_comb begin
        w_next = r_value;
        if (clr) begin
            w_next = 8'h00;
        end else if (inc) begin
            if (w_at_max) begin
                w_next = 8'h00;
            end else if (r_value[3:0] == 4'd9) begin
                w_next = {r_value[7:4] + 4'd1, 4'd0};
            end else begin
                w_next = {r_value[7:4], r_value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 8'h00;
        end else begin
            r_value <= w_next;
        end
    end

endmodule : bcd_mod_counter
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
// Module : time_keeper
// Brief  : BCD time of day advanced on rising edges of the divider level,
//          with a RUN / SET_HR / SET_MIN mode FSM for setting the time.
// Rev    : 1.0
// ============================================================================
module time_keeper
    import clock_pkg::*;
#(
    parameter int unsigned HOURS_MAX = HOURS_MAX_DEF,
    parameter int unsigned MIN_MAX   = MIN_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_src,
    input  logic       en,
    input  logic       mode_btn,
    input  logic       up_btn,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hr_bcd,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       day_wrap
);

    localparam logic [7:0] c_hr_max  = to_bcd(HOURS_MAX);
    localparam logic [7:0] c_min_max = to_bcd(MIN_MAX);

    logic [1:0] r_mode;
    logic [1:0] w_mode_next;
    logic       r_tick_d;
    logic       r_sec_tick;
    logic       r_day_wrap;

    logic w_rise;
    logic w_in_run;
    logic w_in_set_hr;
    logic w_in_set_min;
    logic w_up;
    logic w_adv;
    logic w_sec_clr;
    logic w_min_inc;
    logic w_hr_inc;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_hr_carry;

    // tick_src already lives in the clk domain, so a single delay suffices.
    assign w_rise = tick_src & ~r_tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_RUN:     if (mode_btn) w_mode_next = MODE_SET_HR;
            MODE_SET_HR:  if (mode_btn) w_mode_next = MODE_SET_MIN;
            MODE_SET_MIN: if (mode_btn) w_mode_next = MODE_RUN;
            default:      w_mode_next = MODE_RUN;
        endcase
    end

    always_comb begin
        w_in_run     = (r_mode == MODE_RUN);
        w_in_set_hr  = (r_mode == MODE_SET_HR);
        w_in_set_min = (r_mode == MODE_SET_MIN);
        // A mode press in the same cycle swallows the up press.
        w_up         = up_btn & ~mode_btn;
        w_adv        = w_rise & en & w_in_run;
        w_sec_clr    = w_in_set_min & mode_btn;
    end

    // Carries only ripple from a real advance; set-mode increments stay local.
    assign w_min_inc = w_sec_carry | (w_in_set_min & w_up);
    assign w_hr_inc  = (w_sec_carry & w_min_carry) | (w_in_set_hr & w_up);

    bcd_mod_counter #(.MAX(c_min_max)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_adv),
        .clr   (w_sec_clr),
        .value (sec_bcd),
        .carry (w_sec_carry)
    );

    bcd_mod_counter #(.MAX(c_min_max)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_min_inc),
        .clr   (1'b0),
        .value (min_bcd),
        .carry (w_min_carry)
    );

    bcd_mod_counter #(.MAX(c_hr_max)) u_hr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_hr_inc),
        .clr   (1'b0),
        .value (hr_bcd),
        .carry (w_hr_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d   <= 1'b0;
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
        end else begin
            r_tick_d   <= tick_src;
            r_sec_tick <= w_adv;
            r_day_wrap <= w_sec_carry & w_min_carry & w_hr_carry;
        end
    end

    assign mode     = r_mode;
    assign sec_tick = r_sec_tick;
    assign day_wrap = r_day_wrap;

endmodule : time_keeper
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
// Module : tb_time_keeper
// Brief  : Directed and random stimulus for time_keeper, checked each cycle
//          against a seconds-of-day model plus literal expectations.
// Rev    : 1.0
// ============================================================================
module tb_time_keeper;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick_src = 1'b0;
    logic       en       = 1'b0;
    logic       mode_btn = 1'b0;
    logic       up_btn   = 1'b0;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hr_bcd;
    logic [1:0] mode;
    logic       sec_tick;
    logic       day_wrap;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    time_keeper #(.HOURS_MAX(23), .MIN_MAX(59)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_src (tick_src),
        .en       (en),
        .mode_btn (mode_btn),
        .up_btn   (up_btn),
        .sec_bcd  (sec_bcd),
        .min_bcd  (min_bcd),
        .hr_bcd   (hr_bcd),
        .mode     (mode),
        .sec_tick (sec_tick),
        .day_wrap (day_wrap)
    );

    typedef struct packed {
        int h;
        int m;
        int s;
        int md;
        bit tick_d;
        bit stick;
        bit wrap;
    } model_t;

    model_t mdl = '0;

    // Time is kept as seconds-of-day; a run advance is +1 modulo one day.
    function automatic model_t step(model_t cur, bit t, bit run_en, bit mb, bit ub);
        model_t n;
        int     total;
        n        = cur;
        n.tick_d = t;
        n.stick  = 1'b0;
        n.wrap   = 1'b0;
        case (cur.md)
            0: begin
                if (t && !cur.tick_d && run_en) begin
                    total   = ((cur.h * 60 + cur.m) * 60 + cur.s + 1) % (24 * 3600);
                    n.h     = total / 3600;
                    n.m     = (total / 60) % 60;
                    n.s     = total % 60;
                    n.stick = 1'b1;
                    n.wrap  = (total == 0);
                end
                if (mb) n.md = 1;
            end
            1: begin
                if (mb)      n.md = 2;
                else if (ub) n.h  = (cur.h + 1) % 24;
            end
            2: begin
                if (mb) begin
                    n.md = 0;
                    n.s  = 0;
                end else if (ub) begin
                    n.m = (cur.m + 1) % 60;
                end
            end
            default: n.md = 0;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= '0;
        else        mdl <= step(mdl, tick_src, en, mode_btn, up_btn);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("m_sec",   sec_bcd,        bcd(mdl.s));
            chk("m_min",   min_bcd,        bcd(mdl.m));
            chk("m_hr",    hr_bcd,         bcd(mdl.h));
            chk("m_mode",  {6'd0, mode},   8'(mdl.md));
            chk("m_tick",  {7'd0, sec_tick}, {7'd0, mdl.stick});
            chk("m_wrap",  {7'd0, day_wrap}, {7'd0, mdl.wrap});
        end
    end

    task automatic drive(input logic t, input logic mb, input logic ub);
        tick_src = t;
        mode_btn = mb;
        up_btn   = ub;
        @(posedge clk);
        #2;
        mode_btn = 1'b0;
        up_btn   = 1'b0;
    endtask

    task automatic rises(input int n);
        repeat (n) begin
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic ups(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic press();
        drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        chk({name, "_hr"},  hr_bcd,  h);
        chk({name, "_min"}, min_bcd, m);
        chk({name, "_sec"}, sec_bcd, s);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        @(posedge clk);
        #1;
        chk_time("in_rst", 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        en     = 1'b1;
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk_time("rst", 8'h00, 8'h00, 8'h00);
        chk("rst_mode", {6'd0, mode}, 8'h00);
        chk("rst_tick", {7'd0, sec_tick}, 8'h00);

        // Held level gives exactly one advance.
        drive(1'b1, 1'b0, 1'b0);
        chk("hold_sec", sec_bcd, 8'h01);
        chk("hold_tick", {7'd0, sec_tick}, 8'h01);
        pulses = 0;
        repeat (4) begin
            drive(1'b1, 1'b0, 1'b0);
            pulses = pulses + int'(sec_tick);
        end
        chk("hold_pulses", 8'(pulses), 8'h00);
        chk("hold_sec2", sec_bcd, 8'h01);
        drive(1'b0, 1'b0, 1'b0);

        press();
        chk("set_hr_mode", {6'd0, mode}, 8'h01);
        ups(23);
        chk("hr_23", hr_bcd, 8'h23);
        ups(2);
        chk_time("hr_wrap", 8'h01, 8'h00, 8'h01);
        press();
        chk("set_min_mode", {6'd0, mode}, 8'h02);
        ups(61);
        chk_time("min_wrap", 8'h01, 8'h01, 8'h01);
        press();
        chk("run_mode", {6'd0, mode}, 8'h00);
        chk("sec_clr", sec_bcd, 8'h00);

        rises(2);
        press();
        rises(3);
        chk("frozen_sec", sec_bcd, 8'h02);
        drive(1'b0, 1'b1, 1'b1);
        chk("both_mode", {6'd0, mode}, 8'h02);
        chk("both_hr", hr_bcd, 8'h01);
        press();

        en = 1'b0;
        rises(3);
        chk("en0_sec", sec_bcd, 8'h00);
        en = 1'b1;
        rises(1);
        chk("en1_sec", sec_bcd, 8'h01);

        do_reset();
        rises(5);
        drive(1'b1, 1'b1, 1'b0);
        chk("coinc_sec", sec_bcd, 8'h06);
        chk("coinc_mode", {6'd0, mode}, 8'h01);
        drive(1'b0, 1'b0, 1'b0);
        press();
        press();

        do_reset();
        press(); ups(9); press(); ups(59); press();
        rises(59);
        chk_time("pre_09", 8'h09, 8'h59, 8'h59);
        drive(1'b1, 1'b0, 1'b0);
        chk_time("to_10", 8'h10, 8'h00, 8'h00);
        chk("to_10_tick", {7'd0, sec_tick}, 8'h01);
        chk("to_10_wrap", {7'd0, day_wrap}, 8'h00);
        drive(1'b0, 1'b0, 1'b0);

        press(); ups(13); press(); ups(59); press();
        rises(59);
        chk_time("pre_23", 8'h23, 8'h59, 8'h59);
        drive(1'b1, 1'b0, 1'b0);
        chk_time("day", 8'h00, 8'h00, 8'h00);
        chk("day_tick", {7'd0, sec_tick}, 8'h01);
        chk("day_wrap", {7'd0, day_wrap}, 8'h01);
        drive(1'b0, 1'b0, 1'b0);
        chk("day_wrap_off", {7'd0, day_wrap}, 8'h00);

        do_reset();
        press(); ups(12); press(); ups(34); press();
        rises(56);
        chk_time("pre_arst", 8'h12, 8'h34, 8'h56);
        rst_n = 1'b0;
        #1;
        chk_time("arst", 8'h00, 8'h00, 8'h00);
        chk("arst_mode", {6'd0, mode}, 8'h00);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        repeat (3000) begin
            tick_src = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 9) != 0);
            mode_btn = ($urandom_range(0, 19) == 0);
            up_btn   = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_time_keeper
`default_nettype wire

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Downstream consumer of the clock divider output; tracks time of day as BCD hours, minutes and seconds for the display driver.
- The divider output (tick_src) is a level in the clk domain. This block edge-detects it and advances time once per rising edge, so it never uses tick_src as a clock.
- Includes a small mode FSM so the user can set hours and minutes with debounced button pulses.

Parameters:
- HOURS_MAX, 23, highest hour value (BCD-encoded internally); 23 gives 24-hour mode.
- MIN_MAX, 59, highest minute/second value.

Ports:
- clk  in  1  system clock; same clock as the divider.
- rst_n  in  1  asynchronous active-low reset.
- tick_src  in  1  divider output level; each rising edge is one second.
- en  in  1  run enable; 0 freezes time in RUN.
- mode_btn  in  1  single-cycle debounced pulse; steps the mode FSM.
- up_btn  in  1  single-cycle debounced pulse; increments the field being set.
- sec_bcd  out  8  seconds as BCD, [7:4] tens, [3:0] units.
- min_bcd  out  8  minutes as BCD.
- hr_bcd  out  8  hours as BCD.
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN.
- sec_tick  out  1  one-cycle pulse on each seconds advance.
- day_wrap  out  1  one-cycle pulse on the HOURS_MAX:59:59 -> 00:00:00 transition.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sec/min/hr = 00, mode = RUN (00).
  - sec_tick = 0, day_wrap = 0.
  - Edge register tick_d = 0.
  - Reset while rst_n is low mid-operation overrides everything, including a pending edge.
- Edge detect:
  - tick_d <= tick_src every cycle, in every mode.
  - rise = tick_src & ~tick_d.
  - tick_src is already in the clk domain; no synchronizer.
- Latency:
  - tick_src first sampled 1 at posedge k (with tick_d=0) -> counters and sec_tick update at posedge k.
  - Visible one cycle after tick_src rises.
  - A tick_src held high produces exactly one advance.
- RUN advance (rise & en):
  - Seconds units 0-9, tens 0-5.
  - 59 -> 00 with carry to minutes; minutes likewise carry to hours.
  - Hours 09->10, 19->20, HOURS_MAX->00.
  - sec_tick = 1 for that cycle.
  - day_wrap = 1 only when all three fields wrap in the same cycle.
  - With en=0, rise is discarded; counters hold; sec_tick stays 0.
- FSM:
  - RUN -mode_btn-> SET_HR -mode_btn-> SET_MIN -mode_btn-> RUN.
  - In SET_HR and SET_MIN, rises are ignored (time frozen) and sec_tick/day_wrap stay 0.
  - up_btn in SET_HR: hr +1 modulo HOURS_MAX+1, no carry anywhere.
  - up_btn in SET_MIN: min +1 modulo 60, no carry into hours.
  - up_btn in RUN: ignored.
  - On the SET_MIN->RUN transition, seconds clear to 00.
- Simultaneous events:
  - mode_btn and up_btn in the same cycle: mode_btn wins, up_btn dropped.
  - rise coincident with mode_btn in RUN: rise is applied first (the advance happens), then the mode changes.
  - Illegal mode encoding 11 -> RUN on the next clk.
- All outputs are registered.

Decomposition:
- Package clock_pkg:
  - Mode encodings MODE_RUN, MODE_SET_HR, MODE_SET_MIN.
  - BCD width constant.
  - Default maxima.
- Sub-module bcd_mod_counter #(MAX), instantiated three times:
  - Inputs inc, clr.
  - Outputs value[7:0] and combinational carry (inc & value==MAX).
  - Wraps to 00.
- time_keeper contains the edge detect, the FSM, carry gating and the pulse outputs.

Test Plan:
- Reset then release; no tick -> all fields 00, mode=00, sec_tick=0; pull rst_n low mid-count at 12:34:56 -> 00:00:00 immediately, with no clk edge needed.
- tick_src 0->1 held for 5 cycles -> sec_bcd 00->01 one cycle later; exactly one sec_tick pulse; no further increment.
- Preload 23:59:59 via SET mode, then one rise in RUN -> 00:00:00, sec_tick=1 and day_wrap=1 in the same cycle; 09:59:59 -> 10:00:00 with day_wrap=0.
- mode_btn once, up_btn x25 -> hr goes 00..23 then 01 (wrap at 24), min unchanged.
- Then mode_btn, up_btn x61 -> min=01 and hr unchanged; then mode_btn -> mode=00, sec=00.
- In SET_HR, rises are applied -> no seconds change.
- In RUN with en=0, 3 rises -> no change; en=1 then 1 rise -> +1 s.
- mode_btn and up_btn in the same cycle in SET_HR -> mode=SET_MIN, hr unchanged.
- rise and mode_btn together in RUN at 00:00:05 -> sec=06, mode=SET_HR.
